sao_lcu_feeder: RTL and testbench
=================================

Name: sao_lcu_feeder

Overview:
- Transmit side of the SAO pixel-input interface.
- Reads a raster-stored IMG_W x IMG_H 8-bit image and a per-LCU parameter table from synchronous memories.
- Streams pixels LCU by LCU into the SAO core using in_en/din/busy, with per-LCU sao_* parameters and lcu_x/lcu_y/lcu_size.
- Replaces the behavioural driver in integration and FPGA bring-up.

Parameters:
IMG_W, 128, image width in pixels (power of 2)
IMG_H, 128, image height in pixels (power of 2)
IMG_AW, 14, image memory address width (log2(IMG_W*IMG_H))
PAR_AW, 6, parameter memory address width (>= log2 of max LCU count)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin streaming; sampled only in IDLE or DONE
cfg_lcu_size  in  2  0=16x16, 1=32x32, 2=64x64, 3=reserved
img_addr  out  IMG_AW  image memory read address
img_rdata  in  8  image data; valid the cycle after img_addr is issued
par_addr  out  PAR_AW  parameter memory read address (LCU index n)
par_rdata  in  24  [23:22] type, [21:17] band_pos, [16] eo_class, [15:0] offset; 1-cycle latency
busy  in  1  SAO core back-pressure
in_en  out  1  din valid
din  out  8  pixel
sao_type  out  2  per-LCU parameter
sao_band_pos  out  5  per-LCU parameter
sao_eo_class  out  1  per-LCU parameter
sao_offset  out  16  per-LCU parameter
lcu_x  out  3  LCU column index
lcu_y  out  3  LCU row index
lcu_size  out  2  registered copy of cfg_lcu_size, latched at start
done  out  1  all LCUs transferred

Behaviour:
- Reset: all outputs 0; FSM to IDLE; skid buffer emptied; any in-flight reads discarded. Reset mid-stream aborts immediately with no further in_en.
- Transfer: occurs on each rising edge where in_en=1 and busy=0.
- While busy=1 and in_en=1: din, in_en and all sao_*/lcu_* outputs held stable.
- Geometry: S = 16<<lcu_size; LCUs per row = IMG_W/S; LCU count N = (IMG_W/S)*(IMG_H/S).
  - LCU order: raster (n = lcu_y*(IMG_W/S) + lcu_x).
  - Pixel order within an LCU: raster; pixel (x,y) reads img_addr = (lcu_y*S + y)*IMG_W + lcu_x*S + x.
- FSM states: IDLE, PAR_RD, PAR_LD, STREAM, DONE.
  - IDLE/DONE, start=1, cfg_lcu_size!=3 -> PAR_RD. Latch lcu_size, n=0, done cleared.
  - start with cfg_lcu_size=3 is ignored.
  - PAR_RD: drive par_addr=n -> PAR_LD.
  - PAR_LD: load sao_* from par_rdata; load lcu_x, lcu_y from n -> STREAM.
  - STREAM: issue image reads into a 2-entry skid buffer.
    - A read is issued only if buffer occupancy plus in-flight reads < 2.
    - in_en = buffer non-empty; din = head entry.
    - Exactly one transfer per cycle while busy=0.
  - After the last pixel of LCU n is issued, no further reads. The edge that transfers that pixel moves to PAR_RD with n+1, or to DONE if n = N-1.
- sao_*/lcu_* change only in PAR_LD, so they are constant across all transfers of one LCU.
- Timing, busy low:
  - First in_en=1 in the cycle after the 3rd rising edge following the start sample edge.
  - in_en=0 for exactly 3 cycles between the last transfer of one LCU and the first of the next.
- done: 1 from the edge of the final transfer until the next accepted start or reset. in_en=0 in DONE.
- start in PAR_RD/PAR_LD/STREAM is ignored.
- busy high indefinitely: no reads beyond buffer capacity; nothing lost or duplicated.
- Address arithmetic: unsigned, IMG_AW bits; no wrap occurs for legal sizes.

Optional Feature:
SAO_FEED_CHK_EN:
- Defined: adds output feed_sum [15:0], the modulo-2^16 sum of din over all transfers since the last accepted start. Cleared by reset and by an accepted start; updated on each transfer edge.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Size 32, ramp image (pixel k = k mod 256), busy=0 -> 16384 transfers, order per address formula. LCU n=5: lcu_x=1, lcu_y=1, first din from addr 4128. done rises on the 16384th transfer.
- Size 64 and size 16 -> 4 and 64 LCUs respectively. lcu_x max 1 / 7. sao_* equal par_rdata of index n for every transfer of LCU n.
- Random busy (50%) during size 32 -> din sequence identical to the busy=0 run. Outputs stable whenever busy=1 and in_en=1; no duplicate or missing pixel.
- busy=0 timing: first in_en exactly 3 edges after start. Exactly 3 idle cycles between LCUs.
- Reset asserted mid-LCU 7 -> next cycle all outputs 0. New start restarts at LCU 0, pixel addr 0.
- start with cfg_lcu_size=3, and start pulses mid-stream -> ignored. With SAO_FEED_CHK_EN, ramp image size 32 -> feed_sum = 64*32640 mod 65536 = 57344.

Source files
------------

// File: rtl/sao_lcu_feeder.sv
// sao_lcu_feeder: streams a raster-stored image LCU by LCU into the SAO core.
// Reads pixels and per-LCU parameters from 1-cycle-latency synchronous memories.
// Pixels pass through a 2-entry skid buffer so that in_en/din/sao_* stay put
// while busy is high.
// Optional build macro SAO_FEED_CHK_EN adds feed_sum, a running 16-bit sum of
// transferred pixels.
module sao_lcu_feeder #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int IMG_AW = 14,
  parameter int PAR_AW = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        cfg_lcu_size,
  output logic [IMG_AW-1:0] img_addr,
  input  logic [7:0]        img_rdata,
  output logic [PAR_AW-1:0] par_addr,
  input  logic [23:0]       par_rdata,
  input  logic              busy,
  output logic              in_en,
  output logic [7:0]        din,
  output logic [1:0]        sao_type,
  output logic [4:0]        sao_band_pos,
  output logic              sao_eo_class,
  output logic [15:0]       sao_offset,
  output logic [2:0]        lcu_x,
  output logic [2:0]        lcu_y,
  output logic [1:0]        lcu_size,
  output logic              done
`ifdef SAO_FEED_CHK_EN
  ,
  output logic [15:0]       feed_sum
`endif
);

  localparam int LOG_W = $clog2(IMG_W);
  localparam int LOG_H = $clog2(IMG_H);

  typedef enum logic [2:0] {IDLE, PAR_RD, PAR_LD, STREAM, DONE} state_t;

  state_t            state_q, state_d;
  logic [PAR_AW-1:0] n_q;
  logic [12:0]       pix_cnt_q;
  logic [12:0]       xfer_cnt_q;
  logic [1:0]        occ_q;
  logic              vld_p0;
  logic              vld_p1;
  logic [7:0]        buf0_p2, buf1_p2;
  logic              start_ok, pop, reading, lcu_end, last_lcu;
  logic [IMG_AW-1:0] rd_addr_p0;

  int s_sh, lpr_sh, lx_i, ly_i, px_i, py_i, last_n_i, npix_i, addr_i;

  // LCU geometry, current read address and end-of-image limits
  always_comb begin
    s_sh     = 4 + int'(lcu_size);
    lpr_sh   = LOG_W - s_sh;
    lx_i     = int'(n_q) & ((1 << lpr_sh) - 1);
    ly_i     = int'(n_q) >> lpr_sh;
    px_i     = int'(pix_cnt_q) & ((1 << s_sh) - 1);
    py_i     = int'(pix_cnt_q) >> s_sh;
    addr_i   = (((ly_i << s_sh) + py_i) << LOG_W) + (lx_i << s_sh) + px_i;
    rd_addr_p0 = IMG_AW'(addr_i);
    last_n_i = (1 << (LOG_W + LOG_H - 2 * s_sh)) - 1;
    npix_i   = 1 << (2 * s_sh);
  end

  assign start_ok = start && (cfg_lcu_size != 2'd3) &&
                    ((state_q == IDLE) || (state_q == DONE));
  assign in_en    = (occ_q != 2'd0);
  assign din      = in_en ? buf0_p2 : 8'd0;
  assign pop      = in_en && !busy;
  assign reading  = (state_q == PAR_LD) || (state_q == STREAM);
  // A read may only be issued if the buffer can still absorb it, counting the
  // slot freed by a transfer in this same cycle.
  assign vld_p0   = reading && (int'(pix_cnt_q) != npix_i) &&
                    ((int'(occ_q) + int'(vld_p1) - int'(pop)) < 2);
  assign lcu_end  = pop && (state_q == STREAM) && (int'(xfer_cnt_q) == npix_i - 1);
  assign last_lcu = (int'(n_q) == last_n_i);
  assign img_addr = reading ? rd_addr_p0 : '0;
  assign par_addr = n_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start_ok) state_d = PAR_RD;
      PAR_RD:     state_d = PAR_LD;
      PAR_LD:     state_d = STREAM;
      STREAM:     if (lcu_end) state_d = last_lcu ? DONE : PAR_RD;
      default:    state_d = IDLE;
    endcase
  end

  // Control: counters, buffer occupancy, per-LCU parameter outputs, done flag
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q          <= '0;
      pix_cnt_q    <= '0;
      xfer_cnt_q   <= '0;
      occ_q        <= '0;
      vld_p1       <= 1'b0;
      lcu_size     <= '0;
      sao_type     <= '0;
      sao_band_pos <= '0;
      sao_eo_class <= 1'b0;
      sao_offset   <= '0;
      lcu_x        <= '0;
      lcu_y        <= '0;
      done         <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) pix_cnt_q <= pix_cnt_q + 13'd1;
      if (pop)    xfer_cnt_q <= xfer_cnt_q + 13'd1;
      case ({vld_p1, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
      if (state_q == PAR_LD) begin
        sao_type     <= par_rdata[23:22];
        sao_band_pos <= par_rdata[21:17];
        sao_eo_class <= par_rdata[16];
        sao_offset   <= par_rdata[15:0];
        lcu_x        <= 3'(lx_i);
        lcu_y        <= 3'(ly_i);
      end
      if (lcu_end) begin
        pix_cnt_q  <= '0;
        xfer_cnt_q <= '0;
        if (last_lcu) done <= 1'b1;
        else          n_q  <= n_q + PAR_AW'(1);
      end
      if (start_ok) begin
        lcu_size   <= cfg_lcu_size;
        n_q        <= '0;
        pix_cnt_q  <= '0;
        xfer_cnt_q <= '0;
        done       <= 1'b0;
      end
    end
  end

  // ---- stage p1 -> p2: returning pixel enters the skid buffer ----
  // Skid buffer data: head shifts on transfer, returning pixel fills first free slot
  always_ff @(posedge clk) begin
    if (pop) buf0_p2 <= buf1_p2;
    if (vld_p1) begin
      if ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop)) buf0_p2 <= img_rdata;
      else                                             buf1_p2 <= img_rdata;
    end
  end

`ifdef SAO_FEED_CHK_EN
  // Running modulo-2^16 sum of all transferred pixels since the last accepted start
  always_ff @(posedge clk) begin
    if (reset || start_ok) feed_sum <= '0;
    else if (pop)          feed_sum <= feed_sum + {8'd0, din};
  end
`endif

endmodule

// File: tb/tb_sao_lcu_feeder.sv
// Scoreboard bench for sao_lcu_feeder: a reference model enumerates the
// expected pixel/parameter stream per run; a negedge monitor pops and compares.
module tb_sao_lcu_feeder;
  localparam int W = 128;
  localparam int H = 128;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy = 1'b0;
  logic [1:0]  cfg_lcu_size = 2'd0;
  logic [13:0] img_addr;
  logic [7:0]  img_rdata;
  logic [5:0]  par_addr;
  logic [23:0] par_rdata;
  logic        in_en, sao_eo_class, done;
  logic [7:0]  din;
  logic [1:0]  sao_type, lcu_size;
  logic [4:0]  sao_band_pos;
  logic [15:0] sao_offset;
  logic [2:0]  lcu_x, lcu_y;
`ifdef SAO_FEED_CHK_EN
  logic [15:0] feed_sum;
`endif

  always #5 clk = ~clk;

  sao_lcu_feeder dut (
    .clk(clk), .reset(reset), .start(start), .cfg_lcu_size(cfg_lcu_size),
    .img_addr(img_addr), .img_rdata(img_rdata), .par_addr(par_addr),
    .par_rdata(par_rdata), .busy(busy), .in_en(in_en), .din(din),
    .sao_type(sao_type), .sao_band_pos(sao_band_pos), .sao_eo_class(sao_eo_class),
    .sao_offset(sao_offset), .lcu_x(lcu_x), .lcu_y(lcu_y), .lcu_size(lcu_size),
    .done(done)
`ifdef SAO_FEED_CHK_EN
    , .feed_sum(feed_sum)
`endif
  );

  logic [7:0]  img_mem [0:W*H-1];
  logic [23:0] par_mem [0:63];

  // Synchronous memories with one cycle read latency
  always @(posedge clk) begin
    img_rdata <= img_mem[img_addr];
    par_rdata <= par_mem[par_addr];
  end

  typedef struct packed {
    logic [7:0]  din;
    logic [1:0]  typ;
    logic [4:0]  bp;
    logic        eo;
    logic [15:0] off;
    logic [2:0]  lx;
    logic [2:0]  ly;
    logic [1:0]  sz;
    logic        first;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  bit          mon_en = 0;
  bit          gap_chk = 0;
  bit          busy_rand = 0;
  bit          hold_q = 0;
  bit          want_done = 0;
  logic [40:0] held;
  int          gap = 0;
  int          n_xfer = 0;
  logic [15:0] model_sum;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, req);
  endtask

  function automatic logic [40:0] act_vec();
    return {din, sao_type, sao_band_pos, sao_eo_class, sao_offset, lcu_x, lcu_y, lcu_size, done};
  endfunction

  // Reference model: LCUs in raster order, pixels in raster order within an LCU
  task automatic build(input int sz);
    int s, lpr, nl, addr;
    exp_t e;
    s = 16 << sz;
    lpr = W / s;
    nl = lpr * (H / s);
    exp_q.delete();
    model_sum = 16'd0;
    for (int n = 0; n < nl; n++) begin
      for (int y = 0; y < s; y++) begin
        for (int x = 0; x < s; x++) begin
          addr = ((n / lpr) * s + y) * W + (n % lpr) * s + x;
          e.din   = img_mem[addr];
          e.typ   = par_mem[n][23:22];
          e.bp    = par_mem[n][21:17];
          e.eo    = par_mem[n][16];
          e.off   = par_mem[n][15:0];
          e.lx    = 3'(n % lpr);
          e.ly    = 3'(n / lpr);
          e.sz    = 2'(sz);
          e.first = (n > 0) && (x == 0) && (y == 0);
          e.last  = (n == nl - 1) && (x == s - 1) && (y == s - 1);
          model_sum = model_sum + 16'(e.din);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  // Monitor: compare every transfer, check stability under busy and LCU gaps
  always @(negedge clk) begin
    exp_t e;
    if (!mon_en) begin
      hold_q = 0;
      want_done = 0;
      gap = 0;
    end else begin
      if (want_done) begin
        check("done_rise", {62'd0, in_en, done}, 64'd1);
        want_done = 0;
      end
      if (hold_q) check("hold_stable", 64'(act_vec()), 64'(held));
      hold_q = in_en && busy;
      held = act_vec();
      if (in_en && !busy) begin
        if (exp_q.size() == 0) check("extra_xfer", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          check("xfer", 64'(act_vec()),
                64'({e.din, e.typ, e.bp, e.eo, e.off, e.lx, e.ly, e.sz, 1'b0}));
          if (gap_chk && e.first) check("lcu_gap", 64'(gap), 64'd3);
          if (e.last) want_done = 1;
        end
        n_xfer++;
        gap = 0;
      end else if (!in_en) gap++;
    end
  end

  // Busy driver: random or held low
  initial begin
    forever begin
      @(posedge clk);
      #1;
      busy = busy_rand ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic do_start(input logic [1:0] sz);
    @(posedge clk);
    #1;
    cfg_lcu_size = sz;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int c;
    c = 0;
    while (!done && c < max) begin
      @(negedge clk);
      c++;
    end
    check("done_reached", {63'd0, done}, 64'd1);
    @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string nm);
    check(nm, {img_addr, par_addr, in_en, done, 2'b00, 41'(act_vec())}, 64'd0);
  endtask

  initial begin
    int c;
    for (int i = 0; i < W * H; i++) img_mem[i] = 8'(i);
    for (int i = 0; i < 64; i++) par_mem[i] = 24'($urandom);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    reset = 1'b0;

    // Size 32, random busy, ignored start pulses mid-stream, reset inside LCU 7
    build(1);
    n_xfer = 0;
    mon_en = 1;
    gap_chk = 0;
    busy_rand = 1;
    do_start(2'd1);
    c = 0;
    while (n_xfer < 7 * 1024 + 300 && c < 40000) begin
      @(posedge clk);
      #1;
      c++;
      start = (c == 400) || (c == 2500);
      cfg_lcu_size = start ? 2'($urandom_range(0, 2)) : 2'd1;
    end
    start = 1'b0;
    check("reach_lcu7", {63'd0, n_xfer >= 7 * 1024 + 300}, 64'd1);
    reset = 1'b1;
    mon_en = 0;
    busy_rand = 0;
    @(posedge clk);
    #1;
    check_all_zero("midreset_outputs");
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all_zero("midreset_hold");
    exp_q.delete();

    // Size 32 ramp, busy low: latency, gaps, full order, done
    repeat (2) @(posedge clk);
    build(1);
    n_xfer = 0;
    mon_en = 1;
    gap_chk = 1;
    do_start(2'd1);
    repeat (3) begin
      @(negedge clk);
      check("latency_idle", {63'd0, in_en}, 64'd0);
    end
    @(negedge clk);
    check("latency_first", {63'd0, in_en}, 64'd1);
    wait_done(40000);
    check("xfers_32", 64'(n_xfer), 64'd16384);
`ifdef SAO_FEED_CHK_EN
    check("feed_sum", 64'(feed_sum), 64'(model_sum));
`endif

    // start with reserved size is ignored in DONE
    @(posedge clk);
    #1;
    cfg_lcu_size = 2'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("cfg3_ignored", {62'd0, in_en, done}, 64'd1);

    // Size 64 and size 16 with random image and parameters
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < W * H; i++) img_mem[i] = 8'($urandom);
      for (int i = 0; i < 64; i++) par_mem[i] = 24'($urandom);
      build(k == 0 ? 2 : 0);
      n_xfer = 0;
      do_start(k == 0 ? 2'd2 : 2'd0);
      @(negedge clk);
      check("done_cleared", {63'd0, done}, 64'd0);
      wait_done(40000);
      check("xfers_full", 64'(n_xfer), 64'd16384);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
